instr_encoder: RTL and testbench

Pipelined ARMv4 instruction encoder, the inverse of the family decoder. It takes a one-hot decode family plus instruction fields over a valid/ready handshake and produces the 32-bit instruction word. The word is built so that the family decoder classifies it back into the same family. It sits between the test/boot instruction sequencer and instruction memory, and also drives decode round-trip checks.

---
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ARMv4 instruction encoder: one-hot decode family plus fields in, 32-bit instruction word out.
// Two-stage valid/ready pipeline (encode stage, output register) with delivery and error counters.
module instr_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_family,
   input  logic [3:0]  in_cond,
   input  logic [3:0]  in_op,
   input  logic        in_s,
   input  logic [3:0]  in_rn,
   input  logic [3:0]  in_rd,
   input  logic [3:0]  in_rs,
   input  logic [3:0]  in_rm,
   input  logic [23:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_ir,
   output logic        out_err,
   output logic [15:0] out_count,
   output logic [7:0]  err_count
);

   logic        vld_p1_q, vld_p1_d;
   logic [31:0] ir_p1_q, ir_p1_d;
   logic        err_p1_q, err_p1_d;
   logic        vld_p2_q, vld_p2_d;
   logic [31:0] ir_p2_q, ir_p2_d;
   logic        err_p2_q, err_p2_d;
   logic [15:0] out_count_q, out_count_d;
   logic [7:0]  err_count_q, err_count_d;
   logic        adv_p1, adv_p2, fire_out, req_err;

   function automatic logic is_onehot(input logic [15:0] f);
      return (f != 16'h0000) && ((f & (f - 16'h0001)) == 16'h0000);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'h01;
   endfunction

   // op is {P,U,W,L} for the load/store families; reserved encodings are flagged here
   function automatic logic request_err(input logic [15:0] fam, input logic [3:0] op,
                                        input logic s, input logic [23:0] imm);
      logic bad;
      bad = !is_onehot(fam);
      if ((fam[0] || fam[1] || fam[2]) && (op[3:2] == 2'b10) && !s)
         bad = 1'b1;
      if ((fam[10] || fam[11]) &&
          ((imm[9:8] == 2'b00) || ((op[3:2] == 2'b10) && (op[1:0] == 2'b00))))
         bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [31:0] encode_word(
      input logic [15:0] fam, input logic [3:0] c, input logic [3:0] op, input logic s,
      input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rm,
      input logic [23:0] imm);
      logic [31:0] w;
      case (fam)
         16'h0001: w = {c, 3'b001, op, s, rn, rd, imm[11:0]};
         16'h0002: w = {c, 3'b000, op, s, rn, rd, imm[4:0], imm[6:5], 1'b0, rm};
         16'h0004: w = {c, 3'b000, op, s, rn, rd, rs, 1'b0, imm[6:5], 1'b1, rm};
         16'h0008: w = {c, 6'b000000, op[0], s, rd, rn, rs, 4'b1001, rm};
         16'h0010: w = {c, 5'b00001, op[1], op[0], s, rn, rd, rs, 4'b1001, rm};
         16'h0020: w = {c, 5'b00010, op[0], 2'b00, 4'hF, rd, 12'h000};
         16'h0040: w = {c, 5'b00110, op[0], 2'b10, rn, 4'hF, imm[11:0]};
         16'h0080: w = {c, 5'b00010, op[0], 2'b10, rn, 4'hF, 8'h00, rm};
         16'h0100: w = {c, 3'b010, op[3], op[2], s, op[1], op[0], rn, rd, imm[11:0]};
         16'h0200: w = {c, 3'b011, op[3], op[2], s, op[1], op[0], rn, rd,
                        imm[4:0], imm[6:5], 1'b0, rm};
         16'h0400: w = {c, 3'b000, op[3], op[2], 1'b1, op[1], op[0], rn, rd,
                        imm[7:4], 1'b1, imm[9:8], 1'b1, imm[3:0]};
         16'h0800: w = {c, 3'b000, op[3], op[2], 1'b0, op[1], op[0], rn, rd,
                        4'b0000, 1'b1, imm[9:8], 1'b1, rm};
         16'h1000: w = {c, 5'b00010, s, 2'b00, rn, rd, 4'b0000, 4'b1001, rm};
         16'h2000: w = {c, 3'b100, op[3], op[2], s, op[1], op[0], rn, imm[15:0]};
         16'h4000: w = {c, 3'b101, s, imm};
         16'h8000: w = {c, 3'b011, imm[19:0], 1'b1, imm[23:20]};
         default:  w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   always_comb begin
      adv_p2   = !vld_p2_q || out_ready;
      adv_p1   = !vld_p1_q || adv_p2;
      in_ready = adv_p1;
      fire_out = vld_p2_q && out_ready;
      req_err  = request_err(in_family, in_op, in_s, in_imm);

      // p1: capture request, encode
      vld_p1_d = adv_p1 ? in_valid : vld_p1_q;
      ir_p1_d  = ir_p1_q;
      err_p1_d = err_p1_q;
      if (adv_p1 && in_valid) begin
         err_p1_d = req_err;
         ir_p1_d  = req_err ? 32'h0000_0000 :
                    encode_word(in_family, in_cond, in_op, in_s, in_rn, in_rd, in_rs, in_rm, in_imm);
      end

      // p2: output register
      vld_p2_d = adv_p2 ? vld_p1_q : vld_p2_q;
      ir_p2_d  = ir_p2_q;
      err_p2_d = err_p2_q;
      if (adv_p2 && vld_p1_q) begin
         ir_p2_d  = ir_p1_q;
         err_p2_d = err_p1_q;
      end

      out_count_d = out_count_q + {15'd0, fire_out};
      err_count_d = (fire_out && err_p2_q) ? sat_inc8(err_count_q) : err_count_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1_q    <= 1'b0;
         vld_p2_q    <= 1'b0;
         ir_p2_q     <= 32'h0000_0000;
         err_p2_q    <= 1'b0;
         out_count_q <= 16'h0000;
         err_count_q <= 8'h00;
      end else begin
         vld_p1_q    <= vld_p1_d;
         vld_p2_q    <= vld_p2_d;
         ir_p2_q     <= ir_p2_d;
         err_p2_q    <= err_p2_d;
         out_count_q <= out_count_d;
         err_count_q <= err_count_d;
      end
   end

   // p1 payload is qualified by vld_p1_q, so it needs no reset
   always_ff @(posedge clk) begin
      ir_p1_q  <= ir_p1_d;
      err_p1_q <= err_p1_d;
   end

   assign out_valid = vld_p2_q;
   assign out_ir    = ir_p2_q;
   assign out_err   = err_p2_q;
   assign out_count = out_count_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, backpressure and reset sequences,
// error-counter saturation stream, and randomized traffic against a field-placement model and decoder.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, in_s, out_valid, out_ready, out_err;
   logic [15:0] in_family, out_count;
   logic [3:0]  in_cond, in_op, in_rn, in_rd, in_rs, in_rm;
   logic [23:0] in_imm;
   logic [31:0] out_ir;
   logic [7:0]  err_count;

   int checks = 0;
   int failures = 0;
   int exp_cnt = 0;
   int exp_ecnt = 0;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_family(in_family), .in_cond(in_cond), .in_op(in_op), .in_s(in_s),
      .in_rn(in_rn), .in_rd(in_rd), .in_rs(in_rs), .in_rm(in_rm), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_err(out_err),
      .out_count(out_count), .err_count(err_count)
   );

   typedef struct {
      logic [15:0] fam;
      logic [3:0]  cond;
      logic [3:0]  op;
      logic        s;
      logic [3:0]  rn, rd, rs, rm;
      logic [23:0] imm;
   } req_t;

   typedef struct {
      string       name;
      req_t        r;
      logic [31:0] ir;
      logic        err;
   } vec_t;

   typedef struct {
      logic [31:0] ir;
      logic        err;
      logic [15:0] fam;
      int          stamp;
   } exp_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic req_t mk(input logic [15:0] fam, input logic [3:0] cond, input logic [3:0] op,
                               input logic s, input logic [3:0] rn, input logic [3:0] rd,
                               input logic [3:0] rs, input logic [3:0] rm, input logic [23:0] imm);
      req_t r;
      r.fam = fam; r.cond = cond; r.op = op; r.s = s;
      r.rn = rn; r.rd = rd; r.rs = rs; r.rm = rm; r.imm = imm;
      return r;
   endfunction

   // Reference: legality rules, then the word assembled by adding shifted fields
   function automatic logic model_err(input req_t r);
      int n;
      logic bad;
      n = 0;
      for (int i = 0; i < 16; i++) if (r.fam[i]) n++;
      bad = (n != 1);
      if ((r.fam[0] || r.fam[1] || r.fam[2]) && r.op[3] && !r.op[2] && !r.s) bad = 1'b1;
      if ((r.fam[10] || r.fam[11]) && (r.imm[9:8] == 2'b00)) bad = 1'b1;
      if ((r.fam[10] || r.fam[11]) && (r.op == 4'b1000 || r.op == 4'b1001 ||
          r.op == 4'b1010 || r.op == 4'b1011) && (r.op[1:0] == 2'b00)) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [31:0] model_ir(input req_t r);
      int c, op, s, rn, rd, rs, rm, imm, k, w, puwl;
      if (model_err(r)) return 32'h0;
      c = int'(r.cond); op = int'(r.op); s = int'(r.s); rn = int'(r.rn); rd = int'(r.rd);
      rs = int'(r.rs); rm = int'(r.rm); imm = int'(r.imm);
      k = 0;
      for (int i = 0; i < 16; i++) if (r.fam[i]) k = i;
      puwl = ((op >> 3) & 1) * (1 << 24) + ((op >> 2) & 1) * (1 << 23) +
             ((op >> 1) & 1) * (1 << 21) + (op & 1) * (1 << 20);
      w = c << 28;
      case (k)
         0:  w += (1 << 25) + (op << 21) + (s << 20) + (rn << 16) + (rd << 12) + (imm & 'hFFF);
         1:  w += (op << 21) + (s << 20) + (rn << 16) + (rd << 12) + ((imm & 31) << 7) +
                  (((imm >> 5) & 3) << 5) + rm;
         2:  w += (op << 21) + (s << 20) + (rn << 16) + (rd << 12) + (rs << 8) +
                  (((imm >> 5) & 3) << 5) + 16 + rm;
         3:  w += ((op & 1) << 21) + (s << 20) + (rd << 16) + (rn << 12) + (rs << 8) + 144 + rm;
         4:  w += (1 << 23) + ((op & 3) << 21) + (s << 20) + (rn << 16) + (rd << 12) + (rs << 8) + 144 + rm;
         5:  w += (1 << 24) + ((op & 1) << 22) + (15 << 16) + (rd << 12);
         6:  w += (3 << 24) + ((op & 1) << 22) + (1 << 21) + (rn << 16) + (15 << 12) + (imm & 'hFFF);
         7:  w += (1 << 24) + ((op & 1) << 22) + (1 << 21) + (rn << 16) + (15 << 12) + rm;
         8:  w += (2 << 25) + puwl + (s << 22) + (rn << 16) + (rd << 12) + (imm & 'hFFF);
         9:  w += (3 << 25) + puwl + (s << 22) + (rn << 16) + (rd << 12) + ((imm & 31) << 7) +
                  (((imm >> 5) & 3) << 5) + rm;
         10: w += puwl + (1 << 22) + (rn << 16) + (rd << 12) + (((imm >> 4) & 15) << 8) + 128 +
                  (((imm >> 8) & 3) << 5) + 16 + (imm & 15);
         11: w += puwl + (rn << 16) + (rd << 12) + 128 + (((imm >> 8) & 3) << 5) + 16 + rm;
         12: w += (1 << 24) + (s << 22) + (rn << 16) + (rd << 12) + 144 + rm;
         13: w += (4 << 25) + puwl + (s << 22) + (rn << 16) + (imm & 'hFFFF);
         14: w += (5 << 25) + (s << 24) + imm;
         default: w += (3 << 25) + ((imm & 'hFFFFF) << 5) + 16 + ((imm >> 20) & 15);
      endcase
      return 32'(w);
   endfunction

   // Family decoder used for the round-trip property
   function automatic logic [15:0] decode(input logic [31:0] ir);
      logic [15:0] f;
      f = 16'h0;
      case (ir[27:25])
         3'b000: begin
            if (ir[7:4] == 4'b1001) begin
               if (ir[24:23] == 2'b00)      f[3] = 1'b1;
               else if (ir[24:23] == 2'b01) f[4] = 1'b1;
               else                         f[12] = 1'b1;
            end else if (ir[7] && ir[4]) begin
               if (ir[22]) f[10] = 1'b1; else f[11] = 1'b1;
            end else if (ir[24:23] == 2'b10 && !ir[20]) begin
               if (ir[21]) f[7] = 1'b1; else f[5] = 1'b1;
            end else begin
               if (ir[4]) f[2] = 1'b1; else f[1] = 1'b1;
            end
         end
         3'b001: if (ir[24:23] == 2'b10 && !ir[20]) f[6] = 1'b1; else f[0] = 1'b1;
         3'b010: f[8] = 1'b1;
         3'b011: if (ir[4]) f[15] = 1'b1; else f[9] = 1'b1;
         3'b100: f[13] = 1'b1;
         3'b101: f[14] = 1'b1;
         default: f = 16'h0;
      endcase
      return f;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      int k, a, b;
      k = $urandom_range(0, 15);
      r = mk(16'h0001 << k, 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
             4'($urandom), 4'($urandom), 4'($urandom), 24'($urandom));
      if ((k <= 2) && (r.op[3:2] == 2'b10)) r.s = 1'b1;
      if ((k == 10) || (k == 11)) begin
         if (r.imm[9:8] == 2'b00) r.imm[8] = 1'b1;
         if ((r.op[3:2] == 2'b10) && (r.op[1:0] == 2'b00)) r.op[0] = 1'b1;
      end
      case ($urandom_range(0, 9))
         0: begin
            a = $urandom_range(0, 15);
            b = (a + $urandom_range(1, 15)) % 16;
            r.fam = (16'h0001 << a) | (16'h0001 << b);
         end
         1: r.fam = 16'h0000;
         2: begin r.fam = 16'h0001 << $urandom_range(0, 2); r.op[3:2] = 2'b10; r.s = 1'b0; end
         3: begin r.fam = 16'h0400 << $urandom_range(0, 1); r.imm[9:8] = 2'b00; end
         default: ;
      endcase
      return r;
   endfunction

   task automatic drive(input req_t r);
      in_family = r.fam; in_cond = r.cond; in_op = r.op; in_s = r.s;
      in_rn = r.rn; in_rd = r.rd; in_rs = r.rs; in_rm = r.rm; in_imm = r.imm;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic count_delivery(input logic err);
      exp_cnt = (exp_cnt + 1) % 65536;
      if (err && exp_ecnt < 255) exp_ecnt++;
   endtask

   vec_t vecs[$];
   exp_t q[$];
   req_t cur, ra, rb, rc;
   logic exp_rdy, exp_ov, fin, fout;

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      drive(mk(16'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 24'h0));
      step(); step();
      reset = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_ir", out_ir, 32'h0);
      check("rst_out_err", 32'(out_err), 32'h0);
      check("rst_out_count", 32'(out_count), 32'h0);
      check("rst_err_count", 32'(err_count), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h1);

      vecs.push_back('{"f0_add", mk(16'h0001, 4'hE, 4'b0100, 1'b0, 4'd2, 4'd1, 4'd0, 4'd0, 24'h000005), 32'hE2821005, 1'b0});
      vecs.push_back('{"f14_bl", mk(16'h4000, 4'hE, 4'h0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 24'h000010), 32'hEB000010, 1'b0});
      vecs.push_back('{"f3_mul", mk(16'h0008, 4'hE, 4'h0, 1'b0, 4'd0, 4'd3, 4'd2, 4'd1, 24'h0), 32'hE0030291, 1'b0});
      vecs.push_back('{"f0_tst_s0", mk(16'h0001, 4'hE, 4'b1010, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 24'h0), 32'h0, 1'b1});
      vecs.push_back('{"fam_two_hot", mk(16'h0003, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0), 32'h0, 1'b1});
      vecs.push_back('{"f5_mrs", mk(16'h0020, 4'hE, 4'h0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 24'h0), 32'hE10F1000, 1'b0});
      vecs.push_back('{"f13_stmdb", mk(16'h2000, 4'hE, 4'b1010, 1'b0, 4'd13, 4'd0, 4'd0, 4'd0, 24'h004000), 32'hE92D4000, 1'b0});
      vecs.push_back('{"f10_sh00", mk(16'h0400, 4'hE, 4'b1101, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 24'h000002), 32'h0, 1'b1});
      vecs.push_back('{"f15_undef", mk(16'h8000, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0), 32'hE6000010, 1'b0});
      vecs.push_back('{"f10_ldrh", mk(16'h0400, 4'hE, 4'b1101, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 24'h000102), 32'hE1D100B2, 1'b0});
      vecs.push_back('{"f1_mov", mk(16'h0002, 4'hE, 4'b1101, 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 24'h0), 32'hE1A00001, 1'b0});
      vecs.push_back('{"f1_cmp", mk(16'h0002, 4'hE, 4'b1010, 1'b1, 4'd1, 4'd0, 4'd0, 4'd2, 24'h0), 32'hE1510002, 1'b0});
      vecs.push_back('{"f1_cmp_s0", mk(16'h0002, 4'hE, 4'b1010, 1'b0, 4'd1, 4'd0, 4'd0, 4'd2, 24'h0), 32'h0, 1'b1});
      vecs.push_back('{"f11_rsv", mk(16'h0800, 4'h1, 4'b1000, 1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 24'h000100), 32'h0, 1'b1});

      foreach (vecs[i]) begin
         drive(vecs[i].r);
         in_valid = 1'b1; out_ready = 1'b1;
         step();
         in_valid = 1'b0;
         check({vecs[i].name, "_early_valid"}, 32'(out_valid), 32'h0);
         step();
         check({vecs[i].name, "_valid"}, 32'(out_valid), 32'h1);
         check({vecs[i].name, "_ir"}, out_ir, vecs[i].ir);
         check({vecs[i].name, "_err"}, 32'(out_err), 32'(vecs[i].err));
         step();
         count_delivery(vecs[i].err);
         check({vecs[i].name, "_out_count"}, 32'(out_count), 32'(exp_cnt));
         check({vecs[i].name, "_err_count"}, 32'(err_count), 32'(exp_ecnt));
      end

      // Backpressure: three requests offered while the consumer stalls
      ra = mk(16'h4000, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h000001);
      rb = mk(16'h4000, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h000002);
      rc = mk(16'h4000, 4'hE, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h000003);
      out_ready = 1'b0;
      drive(ra); in_valid = 1'b1;
      check("bp_ready_a", 32'(in_ready), 32'h1);
      step();
      drive(rb);
      check("bp_ready_b", 32'(in_ready), 32'h1);
      step();
      drive(rc);
      check("bp_ready_c_low", 32'(in_ready), 32'h0);
      check("bp_hold_ir", out_ir, model_ir(ra));
      step();
      check("bp_ready_still_low", 32'(in_ready), 32'h0);
      check("bp_hold_stable", out_ir, model_ir(ra));
      check("bp_hold_valid", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      #1;
      check("bp_ready_release", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      check("bp_order_b", out_ir, model_ir(rb));
      step();
      check("bp_order_c", out_ir, model_ir(rc));
      check("bp_c_valid", 32'(out_valid), 32'h1);
      step();
      check("bp_drained", 32'(out_valid), 32'h0);
      exp_cnt += 3;
      check("bp_out_count", 32'(out_count), 32'(exp_cnt));

      // Reset while two words are stalled in the pipeline
      out_ready = 1'b0;
      drive(ra); in_valid = 1'b1;
      step(); step();
      in_valid = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      exp_cnt = 0; exp_ecnt = 0;
      check("rst_stall_valid", 32'(out_valid), 32'h0);
      check("rst_stall_count", 32'(out_count), 32'h0);
      check("rst_stall_err_count", 32'(err_count), 32'h0);
      check("rst_stall_ir", out_ir, 32'h0);
      check("rst_stall_ready", 32'(in_ready), 32'h1);
      step();
      check("rst_stall_no_leak", 32'(out_valid), 32'h0);

      // Back-to-back illegal words: full throughput and err_count saturation
      drive(mk(16'h0000, 4'h0, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0));
      in_valid = 1'b1; out_ready = 1'b1;
      repeat (260) @(posedge clk);
      #1;
      in_valid = 1'b0;
      step(); step();
      exp_cnt = 260; exp_ecnt = 255;
      check("stream_out_count", 32'(out_count), 32'(exp_cnt));
      check("stream_err_sat", 32'(err_count), 32'(exp_ecnt));

      // Randomized traffic against the scoreboard
      for (int j = 0; j < 2500; j++) begin
         if (!in_valid && ($urandom_range(0, 3) != 0)) begin
            cur = rand_req();
            drive(cur);
            in_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         exp_rdy = (q.size() < 2) || out_ready;
         check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
         exp_ov = (q.size() > 0) && (j >= q[0].stamp + 2);
         check("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
         if (out_valid && q.size() > 0) begin
            check("rnd_out_ir", out_ir, q[0].ir);
            check("rnd_out_err", 32'(out_err), 32'(q[0].err));
            if (!q[0].err) check("rnd_roundtrip", 32'(decode(out_ir)), 32'(q[0].fam));
         end
         fin  = in_valid && in_ready;
         fout = out_valid && out_ready;
         step();
         if (fout && q.size() > 0) begin
            count_delivery(q[0].err);
            void'(q.pop_front());
         end
         if (fin) begin
            q.push_back('{model_ir(cur), model_err(cur), cur.fam, j});
            in_valid = 1'b0;
         end
         check("rnd_out_count", 32'(out_count), 32'(exp_cnt));
         check("rnd_err_count", 32'(err_count), 32'(exp_ecnt));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
